// File: rtl/fejkon_pcie_data.sv
// fejkon_pcie_data
//   Minimal PCIe TLP endpoint. It turns single-dword memory TLPs that hit
//   BAR0 into Avalon-MM accesses on the register bus. Reads are answered
//   with a single-beat CplD on the TX stream. Unsupported TLPs are dropped
//   without a completion. The host-bound data sink is always ready and
//   discards what it receives, because the DMA path is not built yet.
//   Only one request is in flight at a time. RX is back-pressured while an
//   access or a completion is pending.
//
// Ports
//   clk, reset            : single rising-edge clock, async active-high reset
//   rx_st_*               : RX TLP stream from the hard IP (256-bit beats)
//   tx_st_*               : TX TLP stream to the hard IP (zero ready latency)
//   bar0_mm_*             : Avalon-MM master towards the BAR0 register file
//   data_tx_*             : host-bound data sink (accepted and discarded)
module fejkon_pcie_data (
  input  logic         clk,
  input  logic         reset,

  input  logic [255:0] rx_st_data,
  input  logic [1:0]   rx_st_empty,
  input  logic         rx_st_error,
  input  logic         rx_st_startofpacket,
  input  logic         rx_st_endofpacket,
  input  logic         rx_st_valid,
  input  logic [7:0]   rx_st_bar,
  output logic         rx_st_ready,
  output logic         rx_st_mask,

  output logic [255:0] tx_st_data,
  output logic         tx_st_startofpacket,
  output logic         tx_st_endofpacket,
  output logic         tx_st_error,
  output logic [1:0]   tx_st_empty,
  output logic         tx_st_valid,
  input  logic         tx_st_ready,

  output logic [31:0]  bar0_mm_address,
  output logic         bar0_mm_read,
  output logic         bar0_mm_write,
  output logic [31:0]  bar0_mm_writedata,
  input  logic [31:0]  bar0_mm_readdata,
  input  logic         bar0_mm_readdatavalid,
  input  logic         bar0_mm_waitrequest,

  input  logic [255:0] data_tx_data,
  input  logic         data_tx_valid,
  input  logic [1:0]   data_tx_channel,
  input  logic         data_tx_startofpacket,
  input  logic         data_tx_endofpacket,
  input  logic [4:0]   data_tx_empty,
  output logic         data_tx_ready
);

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    MM_WRITE,
    MM_READ,
    WAIT_DATA,
    SEND_CPL
  } state_t;

  state_t state_reg;
  state_t state_next;

  // Goes high on the first edge after reset release. It keeps both ready
  // outputs low while reset is asserted and on the cycle it is released.
  logic live_reg;

  // Latched request context
  logic [9:0]  mm_index_reg;   // A[11:2]
  logic [31:0] wdata_reg;
  logic [15:0] req_id_reg;
  logic [7:0]  tag_reg;
  logic [2:0]  tc_reg;
  logic [1:0]  attr_reg;
  logic [6:0]  lo_addr_reg;    // A[6:0]
  logic [31:0] rdata_reg;

  // RX beat split into dword lanes
  logic [31:0] rx_dw [0:7];
  logic [31:0] tx_dw [0:7];

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_lanes
      assign rx_dw[gi] = rx_st_data[32*gi +: 32];
      assign tx_st_data[32*gi +: 32] = tx_dw[gi];
    end
  endgenerate

  logic [31:0] hdr_dw0;
  logic [31:0] hdr_dw1;
  logic [31:0] hdr_addr;
  assign hdr_dw0  = rx_dw[0];
  assign hdr_dw1  = rx_dw[1];
  assign hdr_addr = rx_dw[2];

  logic rx_fire;
  logic is_mrd;
  logic is_mwr;
  logic supported;

  assign rx_fire   = rx_st_valid & rx_st_ready;
  assign is_mrd    = (hdr_dw0[31:24] == 8'h00);
  assign is_mwr    = (hdr_dw0[31:24] == 8'h40) && (hdr_dw1[3:0] == 4'hF);
  assign supported = rx_st_startofpacket && rx_st_bar[0] && !rx_st_error &&
                     (hdr_dw0[9:0] == 10'd1) && (is_mrd || is_mwr);

  // State register and request context
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      live_reg     <= 1'b0;
      mm_index_reg <= '0;
      wdata_reg    <= '0;
      req_id_reg   <= '0;
      tag_reg      <= '0;
      tc_reg       <= '0;
      attr_reg     <= '0;
      lo_addr_reg  <= '0;
      rdata_reg    <= '0;
    end else begin
      state_reg <= state_next;
      live_reg  <= 1'b1;
      if (state_reg == IDLE && rx_fire && supported) begin
        mm_index_reg <= hdr_addr[11:2];
        // A qword-aligned address places the payload after a pad dword.
        wdata_reg    <= hdr_addr[2] ? rx_dw[3] : rx_dw[4];
        req_id_reg   <= hdr_dw1[31:16];
        tag_reg      <= hdr_dw1[15:8];
        tc_reg       <= hdr_dw0[22:20];
        attr_reg     <= hdr_dw0[13:12];
        lo_addr_reg  <= hdr_addr[6:0];
      end
      if (state_reg == WAIT_DATA && bar0_mm_readdatavalid) begin
        rdata_reg <= bar0_mm_readdata;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (rx_fire && rx_st_startofpacket) begin
          if (supported) begin
            state_next = is_mwr ? MM_WRITE : MM_READ;
          end else if (!rx_st_endofpacket) begin
            state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (rx_fire && rx_st_endofpacket) state_next = IDLE;
      end
      MM_WRITE: begin
        if (!bar0_mm_waitrequest) state_next = IDLE;
      end
      MM_READ: begin
        if (!bar0_mm_waitrequest) state_next = WAIT_DATA;
      end
      WAIT_DATA: begin
        if (bar0_mm_readdatavalid) state_next = SEND_CPL;
      end
      SEND_CPL: begin
        if (tx_st_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Completion builder. The empty count is in unused qwords. With data at
  // DW3 the beat ends at DW3 (two spare qwords). With data at DW4 one pad
  // dword is used first, so only one qword is spare.
  logic [31:0] cpl_dw0;
  logic [31:0] cpl_dw1;
  logic [31:0] cpl_dw2;
  assign cpl_dw0 = {8'h4A, 1'b0, tc_reg, 4'b0, 2'b0, attr_reg, 2'b0, 10'd1};
  assign cpl_dw1 = {16'h0000, 3'b000, 1'b0, 12'd4};
  assign cpl_dw2 = {req_id_reg, tag_reg, 1'b0, lo_addr_reg};

  logic in_cpl;
  assign in_cpl = (state_reg == SEND_CPL);

  always_comb begin
    for (int i = 0; i < 8; i++) tx_dw[i] = '0;
    tx_st_empty = 2'd0;
    if (in_cpl) begin
      tx_dw[0] = cpl_dw0;
      tx_dw[1] = cpl_dw1;
      tx_dw[2] = cpl_dw2;
      if (lo_addr_reg[2]) begin
        tx_dw[3]    = rdata_reg;
        tx_st_empty = 2'd2;
      end else begin
        tx_dw[4]    = rdata_reg;
        tx_st_empty = 2'd1;
      end
    end
  end

  assign tx_st_valid         = in_cpl;
  assign tx_st_startofpacket = in_cpl;
  assign tx_st_endofpacket   = in_cpl;
  assign tx_st_error         = 1'b0;

  // Register bus
  logic mm_active;
  assign mm_active         = (state_reg == MM_WRITE) || (state_reg == MM_READ);
  assign bar0_mm_write     = (state_reg == MM_WRITE);
  assign bar0_mm_read      = (state_reg == MM_READ);
  assign bar0_mm_address   = mm_active ? {20'b0, mm_index_reg, 2'b00} : 32'd0;
  assign bar0_mm_writedata = bar0_mm_write ? wdata_reg : 32'd0;

  // RX flow control and data sink
  assign rx_st_ready   = live_reg && ((state_reg == IDLE) || (state_reg == DRAIN));
  assign rx_st_mask    = 1'b0;
  assign data_tx_ready = live_reg;

  // Inputs that are intentionally ignored
  logic unused_inputs;
  assign unused_inputs = ^{rx_st_empty, rx_st_bar[7:1], rx_dw[5], rx_dw[6], rx_dw[7],
                           data_tx_data, data_tx_valid, data_tx_channel,
                           data_tx_startofpacket, data_tx_endofpacket, data_tx_empty};

endmodule

// File: tb/tb_fejkon_pcie_data.sv
// Testbench for fejkon_pcie_data. It sends directed and random TLPs. An
// Avalon-MM slave and a TX sink run alongside them. Every result is checked
// against expectations computed from the TLP fields.
module tb_fejkon_pcie_data;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [255:0] rx_st_data = '0;
  logic [1:0]   rx_st_empty = '0;
  logic         rx_st_error = 1'b0;
  logic         rx_st_startofpacket = 1'b0;
  logic         rx_st_endofpacket = 1'b0;
  logic         rx_st_valid = 1'b0;
  logic [7:0]   rx_st_bar = '0;
  logic         rx_st_ready;
  logic         rx_st_mask;
  logic [255:0] tx_st_data;
  logic         tx_st_startofpacket;
  logic         tx_st_endofpacket;
  logic         tx_st_error;
  logic [1:0]   tx_st_empty;
  logic         tx_st_valid;
  logic         tx_st_ready;
  logic [31:0]  bar0_mm_address;
  logic         bar0_mm_read;
  logic         bar0_mm_write;
  logic [31:0]  bar0_mm_writedata;
  logic [31:0]  bar0_mm_readdata;
  logic         bar0_mm_readdatavalid;
  logic         bar0_mm_waitrequest;
  logic [255:0] data_tx_data = '0;
  logic         data_tx_valid = 1'b0;
  logic [1:0]   data_tx_channel = '0;
  logic         data_tx_startofpacket = 1'b0;
  logic         data_tx_endofpacket = 1'b0;
  logic [4:0]   data_tx_empty = '0;
  logic         data_tx_ready;

  always #5 clk = ~clk;

  fejkon_pcie_data dut (
    .clk(clk), .reset(reset),
    .rx_st_data(rx_st_data), .rx_st_empty(rx_st_empty), .rx_st_error(rx_st_error),
    .rx_st_startofpacket(rx_st_startofpacket), .rx_st_endofpacket(rx_st_endofpacket),
    .rx_st_valid(rx_st_valid), .rx_st_bar(rx_st_bar), .rx_st_ready(rx_st_ready),
    .rx_st_mask(rx_st_mask),
    .tx_st_data(tx_st_data), .tx_st_startofpacket(tx_st_startofpacket),
    .tx_st_endofpacket(tx_st_endofpacket), .tx_st_error(tx_st_error),
    .tx_st_empty(tx_st_empty), .tx_st_valid(tx_st_valid), .tx_st_ready(tx_st_ready),
    .bar0_mm_address(bar0_mm_address), .bar0_mm_read(bar0_mm_read),
    .bar0_mm_write(bar0_mm_write), .bar0_mm_writedata(bar0_mm_writedata),
    .bar0_mm_readdata(bar0_mm_readdata), .bar0_mm_readdatavalid(bar0_mm_readdatavalid),
    .bar0_mm_waitrequest(bar0_mm_waitrequest),
    .data_tx_data(data_tx_data), .data_tx_valid(data_tx_valid),
    .data_tx_channel(data_tx_channel), .data_tx_startofpacket(data_tx_startofpacket),
    .data_tx_endofpacket(data_tx_endofpacket), .data_tx_empty(data_tx_empty),
    .data_tx_ready(data_tx_ready)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check_val(input string tag, input logic [263:0] got, input logic [263:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- Avalon-MM slave model ----------------
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          held;
  } wr_t;

  wr_t         wr_q[$];
  logic [31:0] rd_q[$];
  int          wait_n = 0;
  int          rd_lat = 1;
  logic [31:0] salt = 32'h5A5A_1234;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ salt;
  endfunction

  initial begin
    int acc = 0;
    bit rd_pend = 0;
    int rd_cnt = 0;
    logic [31:0] rd_val = '0;
    bar0_mm_waitrequest   = 1'b0;
    bar0_mm_readdatavalid = 1'b0;
    bar0_mm_readdata      = '0;
    forever begin
      @(posedge clk);
      #2;
      bar0_mm_readdatavalid = 1'b0;
      if (reset) begin
        rd_pend = 0;
        acc = 0;
        bar0_mm_waitrequest = 1'b0;
      end else begin
        if (rd_pend) begin
          if (rd_cnt == 0) begin
            bar0_mm_readdatavalid = 1'b1;
            bar0_mm_readdata      = rd_val;
            rd_pend = 0;
          end else begin
            rd_cnt--;
          end
        end
        if (bar0_mm_write || bar0_mm_read) begin
          bar0_mm_waitrequest = (acc < wait_n);
          if (!bar0_mm_waitrequest) begin
            if (bar0_mm_write) begin
              wr_q.push_back('{bar0_mm_address, bar0_mm_writedata, acc + 1});
            end else begin
              rd_q.push_back(bar0_mm_address);
              rd_pend = 1;
              rd_cnt  = rd_lat - 1;
              rd_val  = mem_val(bar0_mm_address);
            end
            acc = 0;
          end else begin
            acc++;
          end
        end else begin
          bar0_mm_waitrequest = 1'b0;
          acc = 0;
        end
      end
    end
  end

  // ---------------- TX sink model ----------------
  logic [263:0] cpl_q[$];
  int tx_hold = 0;

  initial begin
    int tx_wait = 0;
    bit tx_waiting = 0;
    logic [263:0] tx_prev = '0;
    logic [263:0] cur;
    tx_st_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (reset || !tx_st_valid) begin
        tx_st_ready = 1'b0;
        tx_waiting = 0;
        tx_wait = 0;
      end else begin
        cur = {2'b00, tx_st_startofpacket, tx_st_endofpacket, tx_st_empty, tx_st_data};
        if (tx_waiting) check_val("tx_stable", cur, tx_prev);
        check_val("rx_backpressure", rx_st_ready, 0);
        tx_st_ready = (tx_wait >= tx_hold);
        if (tx_st_ready) begin
          cpl_q.push_back(cur);
          tx_waiting = 0;
          tx_wait = 0;
        end else begin
          tx_prev = cur;
          tx_waiting = 1;
          tx_wait++;
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic rx_beat(input logic [255:0] d, input logic sop, input logic eop,
                         input logic [7:0] bar, input logic err);
    int budget = 200;
    rx_st_data = d;
    rx_st_startofpacket = sop;
    rx_st_endofpacket = eop;
    rx_st_bar = bar;
    rx_st_error = err;
    rx_st_empty = 2'($urandom);
    rx_st_valid = 1'b1;
    while (!rx_st_ready && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    if (budget == 0) check_val("rx_accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    rx_st_valid = 1'b0;
    rx_st_startofpacket = 1'b0;
    rx_st_endofpacket = 1'b0;
    rx_st_error = 1'b0;
  endtask

  task automatic wait_idle();
    int budget = 300;
    while (!(rx_st_ready && !tx_st_valid && !bar0_mm_read && !bar0_mm_write) && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    if (budget == 0) check_val("idle_timeout", 0, 1);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [263:0] last_cpl;
  int n_tlp = 0;

  task automatic run_tlp(input logic [7:0] fmt, input logic [31:0] a, input logic [7:0] bar,
                         input logic err, input logic [9:0] len, input logic [3:0] fbe,
                         input logic [15:0] rid, input logic [7:0] tag, input logic [2:0] tc,
                         input logic [1:0] attr, input int nbeats, input logic [31:0] d3,
                         input logic [31:0] d4, input int exp_held);
    logic [255:0] b;
    logic [31:0]  dw0;
    logic [31:0]  dw1;
    logic [255:0] ed;
    logic [263:0] exp_cpl;
    bit sup, is_wr, is_rd;
    int idx;
    for (int i = 0; i < 8; i++) b[32*i +: 32] = $urandom();
    dw0 = $urandom();
    dw0[31:24] = fmt;
    dw0[22:20] = tc;
    dw0[13:12] = attr;
    dw0[9:0]   = len;
    dw1 = {rid, tag, 4'($urandom), fbe};
    b[31:0] = dw0;
    b[63:32] = dw1;
    b[95:64] = a;
    b[127:96] = d3;
    b[159:128] = d4;

    sup   = bar[0] && !err && (len == 10'd1) && (fmt == 8'h00 || (fmt == 8'h40 && fbe == 4'hF));
    is_wr = sup && (fmt == 8'h40);
    is_rd = sup && (fmt == 8'h00);

    data_tx_valid = 1'($urandom);
    data_tx_data  = {8{$urandom()}};

    for (int i = 0; i < nbeats; i++) begin
      if (i == 0) begin
        rx_beat(b, 1'b1, nbeats == 1, bar, err);
      end else begin
        for (int k = 0; k < 8; k++) b[32*k +: 32] = $urandom();
        rx_beat(b, 1'b0, i == nbeats - 1, bar, 1'b0);
      end
    end
    wait_idle();

    check_val("wr_count", wr_q.size(), is_wr ? 1 : 0);
    if (is_wr && wr_q.size() > 0) begin
      check_val("wr_addr", wr_q[0].addr, a & 32'h0000_0FFC);
      check_val("wr_data", wr_q[0].data, a[2] ? d3 : d4);
      if (exp_held > 0) check_val("wr_held", wr_q[0].held, exp_held);
    end
    check_val("rd_count", rd_q.size(), is_rd ? 1 : 0);
    if (is_rd && rd_q.size() > 0) check_val("rd_addr", rd_q[0], a & 32'h0000_0FFC);
    check_val("cpl_count", cpl_q.size(), is_rd ? 1 : 0);
    if (is_rd && cpl_q.size() > 0) begin
      idx = a[2] ? 3 : 4;
      ed = 256'(32'h4A00_0000 | (32'(tc) << 20) | (32'(attr) << 12) | 32'd1);
      ed = ed | (256'(32'd4) << 32);
      ed = ed | (256'((32'(rid) << 16) | (32'(tag) << 8) | (a & 32'h7F)) << 64);
      ed = ed | (256'(mem_val(a & 32'h0000_0FFC)) << (32 * idx));
      exp_cpl = {2'b00, 1'b1, 1'b1, (idx == 3) ? 2'd2 : 2'd1, ed};
      check_val("cpl_beat", cpl_q[0], exp_cpl);
      last_cpl = cpl_q[0];
    end
    check_val("static_zero", {rx_st_mask, tx_st_error}, 0);

    n_tlp++;
    $display("tlp %0d fmt=%02h a=%08h bar=%02h err=%0b len=%0d be=%h beats=%0d -> %s", n_tlp, fmt, a,
             bar, err, len, fbe, nbeats, is_wr ? "write" : (is_rd ? "read+cpl" : "dropped"));
    wr_q.delete();
    rd_q.delete();
    cpl_q.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    check_val({tag, "_tx"}, {2'b00, tx_st_data, tx_st_startofpacket, tx_st_endofpacket,
                             tx_st_error, tx_st_empty, tx_st_valid}, 0);
    check_val({tag, "_misc"}, {rx_st_ready, rx_st_mask, bar0_mm_address, bar0_mm_read,
                               bar0_mm_write, bar0_mm_writedata, data_tx_ready}, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int budget;
    logic [7:0] fmt;
    logic [9:0] len;
    logic [3:0] be;
    logic [7:0] bar;
    logic err;
    int nb;

    #1 reset = 1'b1;
    #1 check_outputs_zero("reset_state");
    repeat (3) @(posedge clk);
    #4 reset = 1'b0;
    #1 check_val("ready_before_edge", {rx_st_ready, data_tx_ready}, 0);
    @(posedge clk);
    #1 check_val("ready_after_edge", {rx_st_ready, data_tx_ready}, 2'b11);

    // Write with two wait states
    wait_n = 2;
    run_tlp(8'h40, 32'h0000_0010, 8'h01, 0, 10'd1, 4'hF, 16'h0100, 8'h01, 0, 0, 1,
            32'h1111_2222, 32'hDEAD_BEEF, 3);

    // Read of a dword at DW3
    wait_n = 1; rd_lat = 3;
    run_tlp(8'h00, 32'h0000_0014, 8'h01, 0, 10'd1, 4'hF, 16'h0100, 8'h07, 0, 0, 1, 0, 0, -1);
    check_val("cpl_hdr_literal", last_cpl[95:0], {32'h0100_0714, 32'h0000_0004, 32'h4A00_0001});

    // Read with data at DW4 and a slow TX sink
    wait_n = 0; rd_lat = 1; tx_hold = 4;
    run_tlp(8'h00, 32'h0000_0020, 8'h01, 0, 10'd1, 4'hF, 16'hBEEF, 8'h3C, 3'd5, 2'd2, 1, 0, 0, -1);
    check_val("cpl_empty_dw4", last_cpl[257:256], 2'd1);
    tx_hold = 0;

    // TLPs that are dropped
    run_tlp(8'h40, 32'h0000_0010, 8'h00, 0, 10'd1, 4'hF, 16'h0, 8'h0, 0, 0, 1, 0, 32'h1, -1);
    run_tlp(8'h40, 32'h0000_0040, 8'h01, 0, 10'd16, 4'hF, 16'h0, 8'h0, 0, 0, 3, 0, 32'h2, -1);
    run_tlp(8'h40, 32'h0000_0044, 8'h01, 0, 10'd1, 4'h3, 16'h0, 8'h0, 0, 0, 1, 32'h3, 0, -1);
    run_tlp(8'h00, 32'h0000_0048, 8'h01, 1, 10'd1, 4'hF, 16'h0, 8'h0, 0, 0, 2, 0, 0, -1);
    run_tlp(8'h60, 32'h0000_004C, 8'h01, 0, 10'd1, 4'hF, 16'h0, 8'h0, 0, 0, 1, 0, 0, -1);
    // Write with data at DW3 and a high address that must be folded into 4 KiB
    run_tlp(8'h40, 32'hABCD_E7FC, 8'h03, 0, 10'd1, 4'hF, 16'h0, 8'h0, 0, 0, 1,
            32'hCAFE_F00D, 32'h0BAD_0BAD, 1);

    // Reset while waiting for read data
    rd_lat = 30;
    rx_beat({160'd0, 32'h0000_0040, 32'h0200_090F, 32'h0000_0001}, 1'b1, 1'b1, 8'h01, 1'b0);
    budget = 50;
    while (rd_q.size() == 0 && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    check_val("rst_read_issued", rd_q.size(), 1);
    @(posedge clk);
    #4 reset = 1'b1;
    #1 check_outputs_zero("async_reset");
    repeat (2) @(posedge clk);
    #4 reset = 1'b0;
    @(posedge clk);
    #1 check_val("ready_after_reset", {rx_st_ready, data_tx_ready}, 2'b11);
    repeat (40) @(posedge clk);
    #1 check_val("no_cpl_after_reset", cpl_q.size(), 0);
    $display("reset during read: read abandoned");
    wr_q.delete();
    rd_q.delete();
    cpl_q.delete();
    rd_lat = 2;
    run_tlp(8'h00, 32'h0000_0040, 8'h01, 0, 10'd1, 4'hF, 16'h0200, 8'h09, 0, 0, 1, 0, 0, -1);

    // Data sink stream
    for (int i = 0; i < 16; i++) begin
      data_tx_valid = 1'b1;
      data_tx_data = {8{$urandom()}};
      data_tx_startofpacket = (i == 0);
      data_tx_endofpacket = (i == 15);
      @(posedge clk);
      #1;
      check_val("data_tx_ready", data_tx_ready, 1);
      check_val("data_tx_no_effect", {tx_st_valid, bar0_mm_read, bar0_mm_write}, 0);
    end
    data_tx_valid = 1'b0;
    $display("data sink: 16 beats accepted");

    // Random TLPs
    for (int t = 0; t < 60; t++) begin
      wait_n  = $urandom_range(0, 3);
      rd_lat  = $urandom_range(1, 4);
      tx_hold = $urandom_range(0, 3);
      case ($urandom_range(0, 3))
        0, 1: fmt = 8'h40;
        2: fmt = 8'h00;
        default: fmt = 8'($urandom);
      endcase
      len = ($urandom_range(0, 5) == 0) ? 10'($urandom) : 10'd1;
      be  = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'hF;
      bar = 8'($urandom);
      if ($urandom_range(0, 4) != 0) bar[0] = 1'b1;
      err = ($urandom_range(0, 7) == 0);
      if (bar[0] && !err && len == 10'd1 && (fmt == 8'h00 || (fmt == 8'h40 && be == 4'hF)))
        nb = 1;
      else
        nb = $urandom_range(1, 3);
      run_tlp(fmt, $urandom(), bar, err, len, be, 16'($urandom), 8'($urandom), 3'($urandom),
              2'($urandom), nb, $urandom(), $urandom(), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation watchdog expired");
  end

endmodule
